instr_issuer: RTL
=================

Name: instr_issuer

Overview:
- Producer side of the valid/ready instruction handshake into the control FSM.
- Buffers 25-bit instructions written by the loader/host in a small FIFO.
- Presents one instruction at a time on o_valid1/o_instr and holds it stable until the FSM asserts i_ready1.
- Counts issued instructions. Optionally stalls on a register conflict with the previously issued instruction.

Parameters:
- INSTR_W, 25: instruction width; register fields are [24:21] (reg0) and [20:17] (reg1).
- DEPTH, 4: FIFO depth; power of two, at least 2.
- CNT_W, 8: width of the issued-instruction counter.
- HAZARD_GAP, 4: stall cycles inserted on a detected conflict; range 1..15.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_en  in  1  push i_wr_instr into the FIFO.
- i_wr_instr  in  INSTR_W  instruction to enqueue.
- o_full  out  1  FIFO holds DEPTH entries.
- o_empty  out  1  FIFO holds 0 entries.
- o_wr_drop  out  1  one-cycle pulse: a push was rejected.
- o_valid1  out  1  o_instr is valid and offered to the FSM.
- o_instr  out  INSTR_W  FIFO head instruction.
- i_ready1  in  1  FSM can accept an instruction this cycle.
- o_issued_cnt  out  CNT_W  count of completed transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - o_valid1=0, o_instr=0, o_full=0, o_empty=1, o_wr_drop=0, o_issued_cnt=0.
  - FIFO pointers and count cleared; last-issued register invalidated; state S_IDLE.
  - An in-flight offer is abandoned. Nothing is counted.
- Transfer: occurs on a rising edge where o_valid1=1 and i_ready1=1. At that edge the head is popped, o_issued_cnt increments, and the instruction is captured as last-issued.
- Offer stability: once o_valid1=1, o_instr stays constant and o_valid1 stays high until the transfer. Deasserting valid without a transfer is forbidden.
- i_ready1 may be high with o_valid1 low; this has no effect.
- FSM, state register updated on i_clk:
  - S_IDLE: o_valid1=0. If the FIFO is not empty, go to S_GAP when a hazard is detected (feature only), otherwise go to S_ISSUE.
  - S_ISSUE: o_valid1=1. On a transfer, if the FIFO still holds another entry go to S_ISSUE (or S_GAP on hazard), otherwise go to S_IDLE. Back-to-back transfers are allowed: one per clock while i_ready1 stays high.
  - S_GAP: o_valid1=0. The stall counter loads HAZARD_GAP-1 on entry and decrements each cycle; at 0, go to S_ISSUE. Without the feature this state is unreachable.
- o_valid1 is registered (decoded from the state register).
- Latency: push at edge k into an empty FIFO gives o_valid1=1 after edge k+1, so first-word latency is 2 clocks.
- FIFO rules:
  - A push with o_full=1 is dropped and o_wr_drop pulses, even if a pop happens on the same edge. Full is judged on the registered count.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- o_full and o_empty are registered from the count.
- o_issued_cnt wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro: INSTR_ISSUER_HAZARD_STALL_EN.
- With the macro defined, a hazard exists when the last-issued register is valid and either head[24:21] or head[20:17] equals last[24:21]. On a hazard the issuer enters S_GAP for HAZARD_GAP cycles before offering the head.
- Without the macro, no compare logic, stall counter, or last-issued register is built, and heads are offered immediately.

Decomposition:
- Package sck_pkg:
  - INSTR_W.
  - Field constants REG0_HI=24, REG0_LO=21, REG1_HI=20, REG1_LO=17.
  - State encoding S_IDLE/S_ISSUE/S_GAP as 2-bit localparams.
- Sub-module instr_fifo (synchronous FIFO with count, full, empty, drop pulse), parameterised by INSTR_W and DEPTH.
- The FSM, counter and hazard logic live in instr_issuer.

Test Plan:
- Reset mid-offer: push 0x1A00001, wait for o_valid1=1, pulse i_rst_n low for 1 cycle -> o_valid1=0 asynchronously, o_empty=1, o_issued_cnt=0.
- Single transfer, ready held high: push 0x0E20003 at edge 0 -> o_valid1=1 after edge 1; transfer at edge 2; o_issued_cnt=1; o_empty=1.
- Backpressure: push two words, hold i_ready1=0 for 5 cycles -> o_instr equals the first word and stays stable for all 5; then ready=1 for 2 cycles gives two back-to-back transfers in order, o_issued_cnt=2.
- Overflow: DEPTH=4, push 5 words with ready=0 -> o_full=1 after the 4th; 5th gives a one-cycle o_wr_drop pulse; draining yields exactly the first 4 in order.
- Counter wrap: CNT_W=8, 257 transfers -> o_issued_cnt=1.
- With INSTR_ISSUER_HAZARD_STALL_EN, HAZARD_GAP=4: issue reg0=3 then head reg1=3 -> o_valid1 low for exactly 4 cycles between the transfers. Without the macro the same sequence transfers back-to-back.

Source files
------------

// File: rtl/sck_pkg.sv
// Shared definitions for the instruction issuer.
//   INSTR_W              : instruction width
//   REG0_*/REG1_*        : register field positions inside an instruction
//   state_e              : issuer FSM encoding (S_IDLE / S_ISSUE / S_GAP)
//   reg_conflict()       : true when a candidate's reg0 or reg1 equals the
//                          previous instruction's reg0
package sck_pkg;

    localparam int unsigned INSTR_W = 25;

    localparam int unsigned REG0_HI = 24;
    localparam int unsigned REG0_LO = 21;
    localparam int unsigned REG1_HI = 20;
    localparam int unsigned REG1_LO = 17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    function automatic logic reg_conflict(input logic [INSTR_W-1:0] prev,
                                          input logic [INSTR_W-1:0] cand);
        return (cand[REG0_HI:REG0_LO] == prev[REG0_HI:REG0_LO]) ||
               (cand[REG1_HI:REG1_LO] == prev[REG0_HI:REG0_LO]);
    endfunction

endpackage

// File: rtl/instr_issuer_if.sv
// Loader-side write port plus valid/ready instruction handshake of the issuer.
//   slave  : issuer side (takes writes and ready, drives status/valid/instr/count)
//   master : loader/FSM side (the opposite directions)
interface instr_issuer_if #(
    parameter int unsigned CNT_W = 8
);
    import sck_pkg::*;

    logic               i_wr_en;
    logic [INSTR_W-1:0] i_wr_instr;
    logic               o_full;
    logic               o_empty;
    logic               o_wr_drop;
    logic               o_valid1;
    logic [INSTR_W-1:0] o_instr;
    logic               i_ready1;
    logic [CNT_W-1:0]   o_issued_cnt;

    modport slave (
        input  i_wr_en, i_wr_instr, i_ready1,
        output o_full, o_empty, o_wr_drop, o_valid1, o_instr, o_issued_cnt
    );

    modport master (
        output i_wr_en, i_wr_instr, i_ready1,
        input  o_full, o_empty, o_wr_drop, o_valid1, o_instr, o_issued_cnt
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO with registered count, full, empty and drop pulse.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   wr_en_i/wr_data_i : push request; rejected (drop_o pulses) when full_o is set
//   pop_i             : pop the head; ignored when empty
//   head_o / next_o   : oldest entry and the entry behind it
//   count_o           : number of stored entries
//   full_o / empty_o  : registered from the count
//   drop_o            : one-cycle pulse after a rejected push
module instr_fifo #(
    parameter int unsigned INSTR_W = 25,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_en_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic               pop_i,
    output logic [INSTR_W-1:0] head_o,
    output logic [INSTR_W-1:0] next_o,
    output logic [CW-1:0]      count_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               drop_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, empty_q, drop_q;
    logic               push_ok, pop_ok;

    // Full is judged on the registered flag, so a same-edge pop never rescues a push.
    assign push_ok = wr_en_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            drop_q  <= wr_en_i & full_q;
        end
    end

    // Storage carries no reset; stale contents are never offered.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + AW'(1)];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/instr_issuer.sv
// Producer side of the valid/ready instruction handshake into the control FSM.
// Buffers loader writes in instr_fifo, offers the head on o_valid1/o_instr and
// holds it until i_ready1, and counts completed transfers (wrapping).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : write port, status flags, handshake, issued counter
// Optional build macro INSTR_ISSUER_HAZARD_STALL_EN: stall HAZARD_GAP cycles
// before offering a head whose reg0/reg1 equals reg0 of the last issued word.
module instr_issuer
    import sck_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned HAZARD_GAP = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    instr_issuer_if.slave         bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [INSTR_W-1:0] fifo_head, fifo_next;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty, fifo_drop;
    logic               valid, xfer, more;
    logic               haz_head, haz_next;

    assign valid = (state_q == S_ISSUE);
    assign xfer  = valid & bus.i_ready1;
    // Another entry remains behind the head being transferred.
    assign more  = (fifo_count > CW'(1));

    instr_fifo #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .wr_en_i   (bus.i_wr_en),
        .wr_data_i (bus.i_wr_instr),
        .pop_i     (xfer),
        .head_o    (fifo_head),
        .next_o    (fifo_next),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .drop_o    (fifo_drop)
    );

`ifdef INSTR_ISSUER_HAZARD_STALL_EN
    logic [INSTR_W-1:0] last_q;
    logic               last_vld_q;
    logic [3:0]         gap_q;

    assign haz_head = last_vld_q & reg_conflict(last_q, fifo_head);
    // On a transfer the current head becomes last-issued, so compare against it.
    assign haz_next = reg_conflict(fifo_head, fifo_next);
`else
    logic unused_hazard;

    assign haz_head      = 1'b0;
    assign haz_next      = 1'b0;
    assign unused_hazard = ^{fifo_next, 4'(HAZARD_GAP)};
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
`ifdef INSTR_ISSUER_HAZARD_STALL_EN
            last_q     <= '0;
            last_vld_q <= 1'b0;
            gap_q      <= '0;
`endif
        end else begin
            if (xfer) begin
                cnt_q <= cnt_q + CNT_W'(1);
`ifdef INSTR_ISSUER_HAZARD_STALL_EN
                last_q     <= fifo_head;
                last_vld_q <= 1'b1;
`endif
            end
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= haz_head ? S_GAP : S_ISSUE;
`ifdef INSTR_ISSUER_HAZARD_STALL_EN
                        gap_q <= 4'(HAZARD_GAP - 1);
`endif
                    end
                end
                S_ISSUE: begin
                    if (bus.i_ready1) begin
                        if (more) begin
                            state_q <= haz_next ? S_GAP : S_ISSUE;
`ifdef INSTR_ISSUER_HAZARD_STALL_EN
                            gap_q <= 4'(HAZARD_GAP - 1);
`endif
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
`ifdef INSTR_ISSUER_HAZARD_STALL_EN
                    if (gap_q == '0) state_q <= S_ISSUE;
                    else             gap_q   <= gap_q - 4'd1;
`else
                    state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The head cannot move while offered: pops only happen on a transfer.
    assign bus.o_valid1     = valid;
    assign bus.o_instr      = valid ? fifo_head : '0;
    assign bus.o_full       = fifo_full;
    assign bus.o_empty      = fifo_empty;
    assign bus.o_wr_drop    = fifo_drop;
    assign bus.o_issued_cnt = cnt_q;

endmodule
